uart_rx: RTL and testbench



---
 rtl/uart_rx_if.sv | 30 +++
 rtl/uart_rx.sv | 121 ++++++++++++
 tb/tb_uart_rx.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// uart_rx_if: groups the serial receive line, the parity selection and the
// received-frame results of uart_rx.
//   rx            serial line, idle high
//   parity_type   0 = even, 1 = odd
//   rx_msg        last received byte
//   rx_parity     last received parity bit
//   rx_complete   one-cycle frame completion strobe
//   parity_error  received parity differs from expected
//   frame_error   stop bit sampled low
// The slave modport is the receiver. The master modport is the side that
// drives the line and consumes the results.
interface uart_rx_if;
  logic       rx;
  logic       parity_type;
  logic [7:0] rx_msg;
  logic       rx_parity;
  logic       rx_complete;
  logic       parity_error;
  logic       frame_error;

  modport master (
    output rx, parity_type,
    input  rx_msg, rx_parity, rx_complete, parity_error, frame_error
  );

  modport slave (
    input  rx, parity_type,
    output rx_msg, rx_parity, rx_complete, parity_error, frame_error
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: UART receiver on the clk_3125 domain.
// Frame format: start(0), 8 data bits MSB first, parity, stop(1).
// The line is sampled once per bit, at clk_cnt == SAMPLE_POINT.
//   clk_3125  system clock
//   rst       asynchronous active-high reset
//   bus       uart_rx_if.slave: rx, parity_type in; rx_msg, rx_parity,
//             rx_complete, parity_error, frame_error out
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 27,
  parameter int unsigned SAMPLE_POINT = 13
) (
  input  logic     clk_3125,
  input  logic     rst,
  uart_rx_if.slave bus
);

  localparam logic [4:0] CntLast   = 5'(CLKS_PER_BIT - 1);
  localparam logic [4:0] CntSample = 5'(SAMPLE_POINT);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t     state_q;
  logic [1:0] sync_q;
  logic [4:0] clk_cnt_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] shift_q;
  logic       par_rx_q;
  logic [7:0] rx_msg_q;
  logic       rx_parity_q;
  logic       rx_complete_q;
  logic       parity_error_q;
  logic       frame_error_q;

  logic rx_s;
  logic at_sample;
  logic at_wrap;
  logic par_exp;

  assign rx_s      = sync_q[1];
  assign at_sample = (clk_cnt_q == CntSample);
  assign at_wrap   = (clk_cnt_q == CntLast);
  assign par_exp   = bus.parity_type ? ~^shift_q : ^shift_q;

  always_ff @(posedge clk_3125 or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      sync_q         <= '1;
      clk_cnt_q      <= '0;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      par_rx_q       <= 1'b0;
      rx_msg_q       <= '0;
      rx_parity_q    <= 1'b0;
      rx_complete_q  <= 1'b0;
      parity_error_q <= 1'b0;
      frame_error_q  <= 1'b0;
    end else begin
      sync_q        <= {sync_q[0], bus.rx};
      rx_complete_q <= 1'b0;
      clk_cnt_q     <= at_wrap ? '0 : clk_cnt_q + 5'd1;

      case (state_q)
        IDLE: begin
          clk_cnt_q <= '0;
          if (!rx_s) state_q <= START;
        end
        START: begin
          if (at_sample && rx_s) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
          end else if (at_wrap) begin
            state_q   <= DATA;
            bit_cnt_q <= '0;
          end
        end
        DATA: begin
          if (at_sample) shift_q <= {shift_q[6:0], rx_s};
          if (at_wrap) begin
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_q <= '0;
              state_q   <= PARITY;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
        end
        PARITY: begin
          if (at_sample) par_rx_q <= rx_s;
          if (at_wrap) state_q <= STOP;
        end
        STOP: begin
          // Leaving at mid-stop-bit lets a following start bit arrive after
          // a stop bit shorter than a full bit time.
          if (at_sample) begin
            rx_msg_q       <= shift_q;
            rx_parity_q    <= par_rx_q;
            parity_error_q <= (par_rx_q != par_exp);
            frame_error_q  <= ~rx_s;
            rx_complete_q  <= 1'b1;
            state_q        <= IDLE;
            clk_cnt_q      <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rx_msg       = rx_msg_q;
  assign bus.rx_parity    = rx_parity_q;
  assign bus.rx_complete  = rx_complete_q;
  assign bus.parity_error = parity_error_q;
  assign bus.frame_error  = frame_error_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx. The line is driven just after a
// clock edge, as the registered output of a transmitter would be; that edge
// is counted as edge 0 of the frame.
module tb_uart_rx;

  logic clk_3125 = 1'b0;
  logic rst;

  always #5 clk_3125 = ~clk_3125;

  uart_rx_if bus ();

  uart_rx #(
    .CLKS_PER_BIT(27),
    .SAMPLE_POINT(13)
  ) dut (
    .clk_3125(clk_3125),
    .rst     (rst),
    .bus     (bus)
  );

  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  int unsigned pulse_cnt = 0;
  int unsigned pulse_cyc [64];
  logic [7:0]  pulse_msg [64];

  always @(posedge clk_3125) cyc <= cyc + 1;

  always @(negedge clk_3125) begin
    if (bus.rx_complete === 1'b1) begin
      if (pulse_cnt < 64) begin
        pulse_cyc[pulse_cnt] <= cyc;
        pulse_msg[pulse_cnt] <= bus.rx_msg;
      end
      pulse_cnt <= pulse_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic idle(input int unsigned n);
    bus.rx = 1'b1;
    repeat (n) @(posedge clk_3125);
    #1;
  endtask

  // Entered just after an edge; t0 is that edge's cycle number.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                            input int unsigned stop_len, output int unsigned t0);
    logic [10:0] fr;
    fr = {1'b0, d, par, stp};
    t0 = cyc;
    for (int k = 0; k < 11; k++) begin
      bus.rx = fr[10-k];
      repeat ((k == 10) ? stop_len : 27) @(posedge clk_3125);
      #1;
    end
  endtask

  task automatic run_frame(input string tag, input logic [7:0] d, input logic par,
                           input logic stp, input logic pt,
                           input logic exp_perr, input logic exp_ferr);
    int unsigned base, t0;
    bus.parity_type = pt;
    base = pulse_cnt;
    send_frame(d, par, stp, 27, t0);
    idle(40);
    check({tag, "_pulses"}, pulse_cnt, base + 1);
    check({tag, "_latency"}, pulse_cyc[base] - t0, 287);
    check({tag, "_msg"}, bus.rx_msg, d);
    check({tag, "_parity"}, bus.rx_parity, par);
    check({tag, "_perr"}, bus.parity_error, exp_perr);
    check({tag, "_ferr"}, bus.frame_error, exp_ferr);
    check({tag, "_strobe_low"}, bus.rx_complete, 1'b0);
  endtask

  int unsigned base, ta, tb0, tr;

  initial begin
    rst = 1'b1;
    bus.rx = 1'b1;
    bus.parity_type = 1'b0;
    repeat (3) @(posedge clk_3125);
    #1;
    check("rst_msg", bus.rx_msg, 8'h00);
    check("rst_flags", {bus.rx_parity, bus.rx_complete, bus.parity_error, bus.frame_error}, 4'b0000);
    rst = 1'b0;
    idle(10);

    //        tag     data   par   stop  pt    perr  ferr
    run_frame("a5",   8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_frame("3c",   8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    run_frame("01",   8'h01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    run_frame("02",   8'h02, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    run_frame("55",   8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Short low glitch must be rejected as a false start.
    base = pulse_cnt;
    bus.rx = 1'b0;
    repeat (5) @(posedge clk_3125);
    #1;
    idle(400);
    check("glitch_pulses", pulse_cnt, base);
    check("glitch_msg", bus.rx_msg, 8'h55);
    check("glitch_ferr", bus.frame_error, 1'b1);

    // Back-to-back frames with 26-cycle stop bits.
    base = pulse_cnt;
    bus.parity_type = 1'b0;
    send_frame(8'h12, 1'b0, 1'b1, 26, ta);
    send_frame(8'h34, 1'b1, 1'b1, 26, tb0);
    idle(40);
    check("b2b_pulses", pulse_cnt, base + 2);
    check("b2b_lat0", pulse_cyc[base] - ta, 287);
    check("b2b_lat1", pulse_cyc[base+1] - tb0, 287);
    check("b2b_spacing", pulse_cyc[base+1] - pulse_cyc[base], 296);
    check("b2b_msg0", pulse_msg[base], 8'h12);
    check("b2b_msg1", pulse_msg[base+1], 8'h34);
    check("b2b_flags", {bus.rx_parity, bus.parity_error, bus.frame_error}, 3'b100);

    // Reset mid-frame; the rest of this frame after the start bit is all ones
    // so nothing can restart reception once reset is released.
    base = pulse_cnt;
    bus.parity_type = 1'b1;
    fork
      send_frame(8'hFF, 1'b1, 1'b1, 27, tr);
      begin
        repeat (150) @(posedge clk_3125);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_msg", bus.rx_msg, 8'h00);
        check("midrst_flags", {bus.rx_parity, bus.rx_complete, bus.parity_error, bus.frame_error}, 4'b0000);
        repeat (3) @(posedge clk_3125);
        #1;
        rst = 1'b0;
      end
    join
    idle(40);
    check("midrst_pulses", pulse_cnt, base);
    check("midrst_msg_held", bus.rx_msg, 8'h00);

    run_frame("7e",   8'h7E, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
